// File: rtl/step_counter.sv
// step_counter: parametrised up/down counter with programmable terminal value,
// prescaler, synchronous clear/load and wrap-or-saturate behaviour.
// The wrap pulse is registered alongside count so it can feed the enable of a
// chained step_counter as a carry.
module step_counter #(
   parameter int BIT_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,        // async, active low
   input  logic                      en,
   input  logic                      clr,
   input  logic                      load,
   input  logic [BIT_WIDTH-1:0]      load_val,
   input  logic                      up,
   input  logic                      sat,
   input  logic [BIT_WIDTH-1:0]      limit,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [BIT_WIDTH-1:0]      count,
   output logic                      wrap,
   output logic                      at_term
);

   logic [BIT_WIDTH-1:0]      r_count;
   logic                      r_wrap;
   logic [PRESCALE_WIDTH-1:0] r_presc;

   logic                      w_tick;
   logic [BIT_WIDTH-1:0]      w_step_count;
   logic                      w_step_wrap;
   logic [BIT_WIDTH-1:0]      w_count_nxt;
   logic                      w_wrap_nxt;
   logic [PRESCALE_WIDTH-1:0] w_presc_nxt;

   // Tick only on exact equality: a prescale lowered below the running
   // prescaler lets it roll over naturally instead of forcing an early step.
   assign w_tick = en && (r_presc == prescale);

   // Value the counter would take on a step, and whether that step wraps.
   // Counts above limit (from an out-of-range load) wrap going up and
   // decrement normally going down.
   always_comb begin
      w_step_count = r_count;
      w_step_wrap  = 1'b0;
      if (up) begin
         if (r_count < limit) begin
            w_step_count = r_count + 1'b1;
         end else if (!sat) begin
            w_step_count = '0;
            w_step_wrap  = 1'b1;
         end
      end else begin
         if (r_count != '0) begin
            w_step_count = r_count - 1'b1;
         end else if (!sat) begin
            w_step_count = limit;
            w_step_wrap  = 1'b1;
         end
      end
   end

   // Next-state selection: clr beats load beats a prescaled step.
   always_comb begin
      w_count_nxt = r_count;
      w_presc_nxt = r_presc;
      w_wrap_nxt  = 1'b0;
      if (clr) begin
         w_count_nxt = '0;
         w_presc_nxt = '0;
      end else if (load) begin
         w_count_nxt = load_val;
         w_presc_nxt = '0;
      end else if (en) begin
         if (w_tick) begin
            w_presc_nxt = '0;
            w_count_nxt = w_step_count;
            w_wrap_nxt  = w_step_wrap;
         end else begin
            w_presc_nxt = r_presc + 1'b1;
         end
      end
   end

   // State registers; reset clears immediately without a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_presc <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
         r_presc <= w_presc_nxt;
      end
   end

   assign count   = r_count;
   assign wrap    = r_wrap;
   assign at_term = up ? (r_count == limit) : (r_count == '0);

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the counter.
module tb_step_counter;

   localparam int BW = 8;
   localparam int PW = 4;

   logic          clk, rst, en, clr, load, up, sat;
   logic [BW-1:0] load_val, limit;
   logic [PW-1:0] prescale;
   logic [BW-1:0] count;
   logic          wrap, at_term;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   int m_count = 0;
   int m_presc = 0;
   bit m_wrap  = 0;

   step_counter #(.BIT_WIDTH(BW), .PRESCALE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up(up), .sat(sat), .limit(limit),
      .prescale(prescale), .count(count), .wrap(wrap), .at_term(at_term)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: integer arithmetic on the counting rules.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_count = 0; m_presc = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         if (clr) begin
            m_count = 0; m_presc = 0;
         end else if (load) begin
            m_count = int'(load_val); m_presc = 0;
         end else if (en) begin
            if (m_presc == int'(prescale)) begin
               m_presc = 0;
               if (up) begin
                  if (m_count < int'(limit)) m_count = m_count + 1;
                  else if (!sat) begin m_count = 0; m_wrap = 1; end
               end else begin
                  if (m_count > 0) m_count = m_count - 1;
                  else if (!sat) begin m_count = int'(limit); m_wrap = 1; end
               end
            end else begin
               m_presc = (m_presc + 1) % (1 << PW);
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_count", int'(count), m_count);
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("model_at_term", int'(at_term),
          up ? int'(m_count == int'(limit)) : int'(m_count == 0));
   end

   // advance to just after the next falling edge (inputs driven here)
   task automatic cyc();
      @(negedge clk); #1;
   endtask

   initial begin
      int exp_c;
      rst = 0; en = 0; clr = 0; load = 0; up = 1; sat = 0;
      load_val = '0; limit = 8'd4; prescale = '0;
      cyc(); cyc();
      chk("reset_count", int'(count), 0);
      chk("reset_wrap", int'(wrap), 0);
      rst = 1; en = 1;

      // terminal wrap, limit=4
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("wrap_seq_count", int'(count), k % 5);
         chk("wrap_seq_pulse", int'(wrap), int'((k % 5) == 0));
      end

      // down/saturate with prescale=2 from a load of 3
      en = 0; load = 1; load_val = 8'd3;
      cyc();
      chk("load3", int'(count), 3);
      load = 0; up = 0; sat = 1; prescale = 4'd2; en = 1;
      for (int k = 1; k <= 14; k++) begin
         cyc();
         exp_c = 3 - k / 3;
         if (exp_c < 0) exp_c = 0;
         chk("down_sat_count", int'(count), exp_c);
         chk("down_sat_wrap", int'(wrap), 0);
         chk("down_sat_term", int'(at_term), int'(exp_c == 0));
      end

      // priority: clr over load over step
      clr = 1; load = 1; load_val = 8'd9; en = 1;
      cyc();
      chk("prio_clr", int'(count), 0);
      clr = 0; up = 1; sat = 0; limit = 8'd20;
      cyc();
      chk("prio_load", int'(count), 9);
      load = 0;
      cyc(); chk("presc_restart_a", int'(count), 9);
      cyc(); chk("presc_restart_b", int'(count), 9);
      cyc(); chk("presc_restart_c", int'(count), 10);

      // out-of-range load
      prescale = '0; limit = 8'd5; en = 0; load = 1; load_val = 8'd200;
      cyc(); load = 0; en = 1; up = 1;
      cyc();
      chk("oor_up_count", int'(count), 0);
      chk("oor_up_wrap", int'(wrap), 1);
      en = 0; load = 1;
      cyc(); load = 0; en = 1; up = 0;
      cyc();
      chk("oor_dn_count", int'(count), 199);
      chk("oor_dn_wrap", int'(wrap), 0);

      // async reset between edges
      en = 0; load = 1; load_val = 8'd7;
      cyc(); load = 0;
      chk("pre_rst", int'(count), 7);
      #1 rst = 0;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_wrap", int'(wrap), 0);
      cyc(); cyc();
      rst = 1; en = 1; up = 1; limit = 8'd20;
      cyc(); chk("resume_a", int'(count), 1);
      cyc(); chk("resume_b", int'(count), 2);

      // limit=0 wrap mode: stays 0 with wrap held high
      clr = 1;
      cyc(); clr = 0; limit = 8'd0; sat = 0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("lim0_count", int'(count), 0);
         chk("lim0_wrap", int'(wrap), 1);
      end
      up = 0;
      cyc();
      chk("lim0_dn_wrap", int'(wrap), 1);

      // full range: 254 -> 255 -> 0 with one pulse
      limit = 8'd255; up = 1; en = 0; load = 1; load_val = 8'd254;
      cyc(); load = 0; en = 1;
      cyc(); chk("full_255", int'(count), 255); chk("full_255_w", int'(wrap), 0);
      cyc(); chk("full_0", int'(count), 0);     chk("full_0_w", int'(wrap), 1);
      cyc(); chk("full_1", int'(count), 1);     chk("full_1_w", int'(wrap), 0);

      // lowering prescale below the running prescaler: no early tick
      clr = 1;
      cyc(); clr = 0; prescale = 4'd7; limit = 8'd100;
      repeat (5) cyc();
      prescale = 4'd2;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk("presc_lower_hold", int'(count), 0);
      end
      repeat (6) cyc();
      chk("presc_lower_step", int'(count), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised up/down counter with a programmable terminal value, a prescaler, synchronous load/clear and selectable wrap or saturate behaviour. It is the general counting primitive for the keyboard FPGA: matrix scan timing, debounce windows and LED PWM all instantiate it instead of fixed-range counters. `wrap` asserts in the same cycle that `count` first shows the wrapped value. This makes the pulse directly usable as a carry into a chained `step_counter`.

## Interface
- `BIT_WIDTH`, default 8: width of `count`, `limit` and `load_val`.
- `PRESCALE_WIDTH`, default 4: width of the `prescale` input and of the internal prescaler.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Asserted when 0.
- `en`  in  1  count enable. Advances the prescaler.
- `clr`  in  1  synchronous clear.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  BIT_WIDTH  value written by `load`.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `sat`  in  1  mode: 0 wraps, 1 saturates.
- `limit`  in  BIT_WIDTH  terminal value. The counting range is 0..`limit` inclusive.
- `prescale`  in  PRESCALE_WIDTH  the counter steps once every `prescale`+1 enabled cycles.
- `count`  out  BIT_WIDTH  current count (registered).
- `wrap`  out  1  registered one-cycle pulse on wrap-around.
- `at_term`  out  1  combinational. Equals (`up` ? `count`==`limit` : `count`==0).

## Operation
- Reset (`rst`=0, asynchronous): `count`=0, `wrap`=0, prescaler=0. These values are held while `rst`=0.
- Priority at each rising edge: `clr` > `load` > step.
  - `clr`: `count`←0, prescaler←0, `wrap`←0.
  - `load`: `count`←`load_val`, prescaler←0, `wrap`←0. `load_val` greater than `limit` is accepted unchanged.
  - Neither `clr` nor `load`, and `en`=0: prescaler, `count` and direction state hold; `wrap`←0.
- Prescaler and tick:
  - When `en`=1, tick = (prescaler == `prescale`).
  - On tick the prescaler ←0 and the counter steps. Otherwise the prescaler increments by 1.
  - `prescale`=0 gives a step on every enabled cycle.
  - If `prescale` is lowered below the current prescaler value, the prescaler wraps naturally at 2^PRESCALE_WIDTH and no early tick occurs.
- Step, up (`up`=1):
  - `count` < `limit`: `count`+1.
  - `count` ≥ `limit`, wrap mode: `count`←0 and `wrap`←1.
  - `count` ≥ `limit`, saturate mode: `count` holds and `wrap`←0.
- Step, down (`up`=0):
  - `count` > 0: `count`−1. This includes counts above `limit`, which count down normally.
  - `count`==0, wrap mode: `count`←`limit` and `wrap`←1.
  - `count`==0, saturate mode: `count` holds and `wrap`←0.
- `wrap`←0 on every edge that is not a wrapping step.
- Arithmetic is modulo 2^BIT_WIDTH. With `limit`=2^BIT_WIDTH−1 the full range is used with no overflow.
- `limit`=0 in wrap mode: every step wraps, so `count` stays 0 and `wrap` stays high for as long as ticks continue.
- `up`, `sat` and `limit` may change on any cycle. They take effect at the next edge and need no restart.

## Timing
- All state changes on the rising edge of `clk`, apart from the asynchronous reset.
- Latency from a step tick to `count`: 1 cycle.
- `wrap` is high during exactly the cycle after the wrapping edge. `count` already shows 0 (up) or `limit` (down) in that cycle.
- `at_term` has zero latency with respect to `count`, `up` and `limit`.
- Reset deassertion mid-stream: counting resumes on the first edge with `rst`=1, from `count`=0.
- Reset asserted mid-count: `count` and `wrap` clear immediately, without waiting for a clock edge.

## Test plan
- Terminal wrap and pulse:
  - Stimulus: BIT_WIDTH=8, `limit`=4, `prescale`=0, `up`=1, `sat`=0, `en`=1 held for 12 cycles.
  - Response: `count` runs 0,1,2,3,4,0,1,… and `wrap` is high only in the cycles where `count` returns to 0.
- Down/saturate with prescaler:
  - Stimulus: `load_val`=3 loaded, then `up`=0, `sat`=1, `prescale`=2, `en`=1 held.
  - Response: `count` decrements every 3rd cycle 3→2→1→0, then holds at 0; `wrap` never asserts; `at_term`=1 from the cycle `count` reaches 0.
- Priority:
  - Stimulus: `clr`=1, `load`=1 (`load_val`=9) and `en`=1 in the same cycle.
  - Response: `count`=0 next cycle. Then `load` alone gives `count`=9, with the prescaler restarted.
- Out-of-range load:
  - Stimulus: `limit`=5, load 200, `up`=1, wrap mode, one step.
  - Response: `count`=0 and a `wrap` pulse.
  - Stimulus: same setup with `up`=0.
  - Response: `count`=199.
- Async reset:
  - Stimulus: drive `rst`=0 between clock edges while `count`=7.
  - Response: `count`=0 and `wrap`=0 before the next edge. Counting resumes from 0 on the first edge after `rst`=1.
- Edge cases:
  - Stimulus: `limit`=0, wrap mode, `en`=1.
  - Response: `count` stays 0 and `wrap` stays high.
  - Stimulus: `limit`=255 counting up.
  - Response: 254→255→0 with one `wrap` pulse.
